// File: rtl/peripheral_pwm_multi.sv
// Bus-mapped multi-channel PWM: one shared period counter, per-channel duty and polarity,
// shadowed period/duty committed atomically at the period boundary, sticky wrap interrupt.
module peripheral_pwm_multi #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     d_in,
    input  logic            cs,
    input  logic [4:0]      addr,
    input  logic            rd,
    input  logic            wr,
    output logic [31:0]     d_out,
    output logic [N_CH-1:0] pwmout,
    output logic            irq
);

    localparam logic [4:0] AddrCtrl   = 5'h00;
    localparam logic [4:0] AddrPeriod = 5'h02;
    localparam logic [4:0] AddrStatus = 5'h04;
    localparam logic [4:0] AddrCount  = 5'h06;
    localparam logic [4:0] AddrDuty0  = 5'h10;

    logic             run_q, run_d;
    logic             irq_en_q, irq_en_d;
    logic [N_CH-1:0]  en_q, en_d;
    logic [N_CH-1:0]  inv_q, inv_d;
    logic [N_CH-1:0]  pwm_q, pwm_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_sh_q  [N_CH];
    logic [CNT_W-1:0] duty_sh_d  [N_CH];
    logic [CNT_W-1:0] duty_act_q [N_CH];
    logic [CNT_W-1:0] duty_act_d [N_CH];
    logic             wrap_q, wrap_d;
    logic [31:0]      d_out_q, d_out_d;
    logic             bus_wr, bus_rd, at_wrap;
    logic             unused_d_in;

    assign bus_wr      = cs & wr;
    assign bus_rd      = cs & rd;
    assign at_wrap     = run_q && (cnt_q == period_act_q);
    assign unused_d_in = ^d_in;

    // Read mux samples pre-write register values, so a read+write returns the old value.
    always_comb begin : read_mux
        d_out_d = '0;
        if (bus_rd) begin
            case (addr)
                AddrCtrl: begin
                    d_out_d[0]           = run_q;
                    d_out_d[1]           = irq_en_q;
                    d_out_d[8 +: N_CH]   = en_q;
                    d_out_d[16 +: N_CH]  = inv_q;
                end
                AddrPeriod: d_out_d    = 32'(period_sh_q);
                AddrStatus: d_out_d[0] = wrap_q;
                AddrCount:  d_out_d    = 32'(cnt_q);
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (addr == AddrDuty0 + 5'(2 * i)) d_out_d = 32'(duty_sh_q[i]);
                    end
                end
            endcase
        end
    end

    always_comb begin : reg_write
        run_d       = run_q;
        irq_en_d    = irq_en_q;
        en_d        = en_q;
        inv_d       = inv_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        if (bus_wr) begin
            case (addr)
                AddrCtrl: begin
                    run_d    = d_in[0];
                    irq_en_d = d_in[1];
                    en_d     = d_in[8 +: N_CH];
                    inv_d    = d_in[16 +: N_CH];
                end
                AddrPeriod: period_sh_d = d_in[CNT_W-1:0];
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (addr == AddrDuty0 + 5'(2 * i)) duty_sh_d[i] = d_in[CNT_W-1:0];
                    end
                end
            endcase
        end
    end

    // While stopped the actives track the shadows, so a restart begins with current shadows.
    always_comb begin : count_next
        cnt_d        = cnt_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (!run_q || at_wrap) begin
            cnt_d        = '0;
            period_act_d = period_sh_q;
            duty_act_d   = duty_sh_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin : status_next
        wrap_d = wrap_q;
        if (bus_wr && (addr == AddrStatus) && d_in[0]) wrap_d = 1'b0;
        if (at_wrap) wrap_d = 1'b1;
    end

    always_comb begin : pwm_next
        pwm_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            pwm_d[i] = (run_q & en_q[i] & (cnt_q < duty_act_q[i])) ^ inv_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            en_q         <= '0;
            inv_q        <= '0;
            pwm_q        <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            cnt_q        <= '0;
            wrap_q       <= 1'b0;
            d_out_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            run_q        <= run_d;
            irq_en_q     <= irq_en_d;
            en_q         <= en_d;
            inv_q        <= inv_d;
            pwm_q        <= pwm_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
            wrap_q       <= wrap_d;
            d_out_q      <= d_out_d;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign d_out  = d_out_q;
    assign pwmout = pwm_q;
    assign irq    = wrap_q & irq_en_q;

endmodule

// File: tb/tb_peripheral_pwm_multi.sv
// Scoreboard bench: three PWM instances (4x16, 1x8, 8x32) share one bus; a spec-level model
// queues expected d_out/pwmout/irq per edge and a monitor compares after each edge.
module tb_peripheral_pwm_multi;

    localparam int NI = 3;

    typedef struct packed {
        logic [NI-1:0][31:0] dout;
        logic [NI-1:0][7:0]  pwm;
        logic [NI-1:0]       irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, cs, rd, wr;
    logic [4:0]  addr;
    logic [31:0] d_in;
    logic [31:0] dout0, dout1, dout2;
    logic [3:0]  pw0;
    logic [0:0]  pw1;
    logic [7:0]  pw2;
    logic        irq0, irq1, irq2;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t cur;

    int cfg_nch[NI] = '{4, 1, 8};
    int cfg_cw[NI]  = '{16, 8, 32};

    // Reference model state, per instance
    bit              m_run[NI], m_ien[NI], m_wrap[NI];
    bit [7:0]        m_en[NI], m_inv[NI];
    longint unsigned m_psh[NI], m_pact[NI], m_cnt[NI];
    longint unsigned m_dsh[NI][8];
    longint unsigned m_dact[NI][8];

    always #5 clk = ~clk;

    peripheral_pwm_multi #(.N_CH(4), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(dout0), .pwmout(pw0), .irq(irq0)
    );
    peripheral_pwm_multi #(.N_CH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(dout1), .pwmout(pw1), .irq(irq1)
    );
    peripheral_pwm_multi #(.N_CH(8), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(dout2), .pwmout(pw2), .irq(irq2)
    );

    function automatic longint unsigned cmask(int k);
        return (cfg_cw[k] >= 32) ? 64'hFFFF_FFFF : ((64'd1 << cfg_cw[k]) - 64'd1);
    endfunction

    function automatic bit [7:0] chmask(int k);
        return 8'((16'd1 << cfg_nch[k]) - 16'd1);
    endfunction

    // Index of a DUTY register for this address, or -1 if the address is not one.
    function automatic int duty_idx(int k, logic [4:0] a);
        int idx;
        idx = (int'(a) - 16) / 2;
        if (a >= 5'h10 && a[0] == 1'b0 && idx < cfg_nch[k]) return idx;
        return -1;
    endfunction

    function automatic longint unsigned mread(int k, logic [4:0] a);
        int idx;
        case (a)
            5'h00: return longint'(m_run[k]) | (longint'(m_ien[k]) << 1) |
                          (longint'(m_en[k]) << 8) | (longint'(m_inv[k]) << 16);
            5'h02: return m_psh[k];
            5'h04: return longint'(m_wrap[k]);
            5'h06: return m_cnt[k];
            default: begin
                idx = duty_idx(k, a);
                if (idx >= 0) return m_dsh[k][idx];
                return 0;
            end
        endcase
    endfunction

    task automatic model_edge(input logic r, c, rdd, wrr, input logic [4:0] a,
                              input logic [31:0] d);
        exp_t e;
        bit   wrapped;
        int   idx;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                m_run[k] = 0; m_ien[k] = 0; m_wrap[k] = 0; m_en[k] = 0; m_inv[k] = 0;
                m_psh[k] = 0; m_pact[k] = 0; m_cnt[k] = 0;
                for (int j = 0; j < 8; j++) begin
                    m_dsh[k][j]  = 0;
                    m_dact[k][j] = 0;
                end
            end else begin
                if (c && rdd) e.dout[k] = 32'(mread(k, a));
                for (int i = 0; i < cfg_nch[k]; i++) begin
                    e.pwm[k][i] = (m_run[k] && m_en[k][i] && (m_cnt[k] < m_dact[k][i]))
                                  ^ m_inv[k][i];
                end
                wrapped = 0;
                if (!m_run[k] || m_cnt[k] == m_pact[k]) begin
                    wrapped   = m_run[k];
                    m_cnt[k]  = 0;
                    m_pact[k] = m_psh[k];
                    for (int j = 0; j < 8; j++) m_dact[k][j] = m_dsh[k][j];
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                if (c && wrr) begin
                    case (a)
                        5'h00: begin
                            m_run[k] = d[0];
                            m_ien[k] = d[1];
                            m_en[k]  = d[15:8] & chmask(k);
                            m_inv[k] = d[23:16] & chmask(k);
                        end
                        5'h02: m_psh[k] = longint'(d) & cmask(k);
                        5'h04: if (d[0]) m_wrap[k] = 0;
                        default: begin
                            idx = duty_idx(k, a);
                            if (idx >= 0) m_dsh[k][idx] = longint'(d) & cmask(k);
                        end
                    endcase
                end
                if (wrapped) m_wrap[k] = 1;
            end
            e.irq[k] = m_wrap[k] & m_ien[k];
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("d_out", 0, dout0, cur.dout[0]);
            chk("d_out", 1, dout1, cur.dout[1]);
            chk("d_out", 2, dout2, cur.dout[2]);
            chk("pwmout", 0, 32'(pw0), 32'(cur.pwm[0]));
            chk("pwmout", 1, 32'(pw1), 32'(cur.pwm[1]));
            chk("pwmout", 2, 32'(pw2), 32'(cur.pwm[2]));
            chk("irq", 0, 32'(irq0), 32'(cur.irq[0]));
            chk("irq", 1, 32'(irq1), 32'(cur.irq[1]));
            chk("irq", 2, 32'(irq2), 32'(cur.irq[2]));
        end
    end

    task automatic step(input logic r, c, rdd, wrr, input logic [4:0] a, input logic [31:0] d);
        rst = r; cs = c; rd = rdd; wr = wrr; addr = a; d_in = d;
        model_edge(r, c, rdd, wrr, a, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [4:0] a);
        step(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    // Advance until the next edge sees instance 0 running at counter value v.
    task automatic wait_cnt(input longint unsigned v);
        for (int n = 0; n < 1000 && !(m_run[0] && m_cnt[0] == v); n++) idle(1);
    endtask

    task automatic wait_wrap();
        for (int n = 0; n < 1000 && !(m_run[0] && m_cnt[0] == m_pact[0]); n++) idle(1);
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rdat;
        int          sel;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'h0; d_in = 32'h0;

        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 5'h00, 32'h0000_0303);
        rd_reg(5'h00); rd_reg(5'h06); rd_reg(5'h04); idle(2);

        wr_reg(5'h02, 32'd9); wr_reg(5'h10, 32'd3); wr_reg(5'h00, 32'h0000_0101);
        repeat (25) rd_reg(5'h06);

        wr_reg(5'h12, 32'd0); wr_reg(5'h14, 32'd10); wr_reg(5'h16, 32'd10);
        wr_reg(5'h00, 32'h0008_0F03);
        idle(30);

        wait_cnt(4); wr_reg(5'h10, 32'd7); rd_reg(5'h10); idle(25);

        wr_reg(5'h04, 32'd1); idle(3); rd_reg(5'h04);
        wait_wrap(); wr_reg(5'h04, 32'd1); rd_reg(5'h04); idle(3);

        step(1'b0, 1'b1, 1'b1, 1'b1, 5'h02, 32'd5); rd_reg(5'h02); idle(12);

        wait_cnt(3); wr_reg(5'h00, 32'h0008_0F02); idle(4); rd_reg(5'h06);
        wr_reg(5'h00, 32'h0008_0F03); idle(12);

        for (int i = 0; i < 8; i++) wr_reg(5'(16 + 2 * i), 32'h1000_0000 + 32'(i * 3 + 1));
        for (int a = 0; a < 32; a++) rd_reg(5'(a));

        wr_reg(5'h02, 32'd255); wr_reg(5'h10, 32'd100); idle(530); rd_reg(5'h06);

        for (int n = 0; n < 2500; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: begin
                    ra = 5'h00; rdat = $urandom;
                    rdat[0] = ($urandom_range(0, 5) != 0);
                end
                1:       begin ra = 5'h02; rdat = $urandom_range(0, 20); end
                2, 3:    begin ra = 5'(16 + 2 * $urandom_range(0, 7)); rdat = $urandom_range(0, 24); end
                4:       begin ra = 5'h04; rdat = $urandom; end
                5:       begin ra = 5'h06; rdat = $urandom; end
                default: begin ra = 5'($urandom); rdat = $urandom; end
            endcase
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, ra, rdat);
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
